data_memory_sized: RTL and testbench

- Parametrised successor to the single-cycle doubleword data memory used by the RV64 datapath.
- Byte-addressed; supports RV64 load/store sizes (B/H/W/D) with sign/zero extension and byte-lane merging on stores.
- Adds a valid/ready request port, a configurable wait-state counter and a one-cycle response pulse with an error flag for misaligned or out-of-range accesses.
- Sits between the MEM pipeline stage and the storage array; the MEM stage stalls while req_ready is low.

---
 rtl/data_memory_sized.sv | 247 ++++++++++++++++++++++++
 tb/tb_data_memory_sized.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_sized.sv
// ---------------------------------------------------------------------------
// data_memory_sized
//
// Byte-addressed doubleword data memory for the RV64 MEM stage. A request is
// taken over a valid/ready handshake, optionally delayed by a programmable
// number of wait states, then executed and answered with a one-cycle
// response pulse. Loads and stores of 1, 2, 4 or 8 bytes are supported, with
// byte-lane merging on stores and sign/zero extension on loads. Misaligned
// and out-of-range accesses are rejected with resp_err and never touch the
// storage array.
//
// Parameters
//   DEPTH        number of 64-bit doublewords (power of two, >= 2)
//   ADDR_W       request address width
//   WAIT_CYCLES  extra cycles between accept and execute (0..15)
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous active-high reset
//   req_valid     request present
//   req_ready     idle, a request will be accepted this cycle
//   req_wr        1 = store, 0 = load
//   req_addr      byte address
//   req_size      0 = byte, 1 = half, 2 = word, 3 = double
//   req_unsigned  zero-extend loads when 1, sign-extend when 0
//   req_wdata     right-aligned store data
//   resp_valid    one-cycle completion pulse
//   resp_rdata    extended load data (0 for stores and errors)
//   resp_err      misaligned or out-of-range access, qualified by resp_valid
//
// Build option
//   DMEM_PRELOAD_EN  when defined, reset loads doublewords 0..4 with the
//                    values 1..5; otherwise the reset image is all zero.
// ---------------------------------------------------------------------------
module data_memory_sized #(
    parameter int DEPTH       = 32,
    parameter int ADDR_W      = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    output logic [63:0]       resp_rdata,
    output logic              resp_err
);

    localparam int IDX_W = $clog2(DEPTH);

    // First byte address past the end of the array.
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH) << 3;

    // Counter value on which WAIT hands over to EXEC.
    localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

`ifdef DMEM_PRELOAD_EN
    localparam bit PRELOAD = 1'b1;
`else
    localparam bit PRELOAD = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_EXEC,
        S_RESP
    } state_t;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic accept;

    // Latched request; everything downstream uses these copies only.
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [63:0]       wdata_q;

    logic [63:0] mem_q [DEPTH];
    logic [63:0] rdata_q;
    logic        err_q;

    logic [2:0]       off;
    logic [IDX_W-1:0] idx;
    logic             oor;
    logic             mis;
    logic             err;

    // -----------------------------------------------------------------------
    // Helper functions
    // -----------------------------------------------------------------------
    function automatic logic [63:0] reset_image(input int i);
        return (PRELOAD && (i < 5)) ? 64'(i + 1) : 64'd0;
    endfunction

    // Replace only the lanes off .. off+2^size-1 of the old doubleword.
    function automatic logic [63:0] merge_store(input logic [63:0] old,
                                                input logic [63:0] wd,
                                                input logic [2:0]  o,
                                                input logic [1:0]  sz);
        logic [8:0]  mask;
        logic [7:0]  be;
        logic [63:0] sh;
        logic [63:0] res;
        mask = (9'd1 << (4'd1 << sz)) - 9'd1;
        be   = mask[7:0] << o;
        sh   = wd << {o, 3'b000};
        for (int b = 0; b < 8; b++) begin
            res[8*b +: 8] = be[b] ? sh[8*b +: 8] : old[8*b +: 8];
        end
        return res;
    endfunction

    // Right-align the addressed field and extend it to 64 bits.
    function automatic logic [63:0] load_extend(input logic [63:0] word,
                                                input logic [2:0]  o,
                                                input logic [1:0]  sz,
                                                input logic        uns);
        logic [63:0] sh;
        logic [63:0] res;
        sh = word >> {o, 3'b000};
        case (sz)
            2'd0:    res = uns ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
            2'd1:    res = uns ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
            2'd2:    res = uns ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    // -----------------------------------------------------------------------
    // Address decode and error detection on the latched request
    // -----------------------------------------------------------------------
    assign off = addr_q[2:0];
    assign idx = addr_q[IDX_W+2:3];
    // Full-width compare so high addresses cannot alias onto low indices.
    assign oor = (addr_q >= LIMIT);

    always_comb begin
        mis = 1'b0;
        case (size_q)
            2'd1:    mis = addr_q[0];
            2'd2:    mis = |addr_q[1:0];
            2'd3:    mis = |addr_q[2:0];
            default: mis = 1'b0;
        endcase
    end

    assign err = oor | mis;

    // -----------------------------------------------------------------------
    // Control FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                cnt_d     = 4'd0;
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_EXEC;
                end
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = S_EXEC;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_EXEC: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Request capture
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q    <= req_wr;
            addr_q  <= req_addr;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            wdata_q <= req_wdata;
        end
    end

    // -----------------------------------------------------------------------
    // Storage array and response data, updated on the edge leaving EXEC.
    // Reset reloads the image, so an interrupted store never lands.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= reset_image(i);
            end
        end else if (state_q == S_EXEC) begin
            err_q <= err;
            if (err) begin
                rdata_q <= 64'd0;
            end else if (wr_q) begin
                rdata_q    <= 64'd0;
                mem_q[idx] <= merge_store(mem_q[idx], wdata_q, off, size_q);
            end else begin
                rdata_q <= load_extend(mem_q[idx], off, size_q, uns_q);
            end
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_data_memory_sized.sv
module tb_data_memory_sized;

`ifdef DMEM_PRELOAD_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          cyc;
        int          w;
        int          id;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_wr;
    logic [63:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_wdata;

    // Instance 0: WAIT_CYCLES=0, 1: WAIT_CYCLES=1, 2: WAIT_CYCLES=4
    logic        vld [3];
    logic        rdy [3];
    logic        rv  [3];
    logic [63:0] rd  [3];
    logic        er  [3];

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   req_id = 0;
    exp_t sbq [$];
    logic [63:0] exp_mem [32];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_memory_sized #(.DEPTH(32), .ADDR_W(64), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(vld[0]), .req_ready(rdy[0]),
        .req_wr(req_wr), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .resp_valid(rv[0]), .resp_rdata(rd[0]), .resp_err(er[0]));

    data_memory_sized #(.DEPTH(32), .ADDR_W(64), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(vld[1]), .req_ready(rdy[1]),
        .req_wr(req_wr), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .resp_valid(rv[1]), .resp_rdata(rd[1]), .resp_err(er[1]));

    data_memory_sized #(.DEPTH(32), .ADDR_W(64), .WAIT_CYCLES(4)) dut4 (
        .clk(clk), .reset(reset), .req_valid(vld[2]), .req_ready(rdy[2]),
        .req_wr(req_wr), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .resp_valid(rv[2]), .resp_rdata(rd[2]), .resp_err(er[2]));

    function automatic int wl(input int w);
        return (w == 0) ? 0 : ((w == 1) ? 1 : 4);
    endfunction

    function automatic logic [63:0] img(input int i);
        return (PRE && (i < 5)) ? 64'(i + 1) : 64'd0;
    endfunction

    task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (req %0d): got %h, expected %h", nm, id, act, exp);
        end
    endtask

    // Present a request on instance w and queue its expected response.
    // The response cycle is counted inclusively from the accepting edge:
    // RESP is entered WAIT_CYCLES+2 edges later.
    task automatic do_req(input int w, input logic wr, input logic [63:0] addr,
                          input logic [1:0] sz, input logic uns, input logic [63:0] wd,
                          input logic [63:0] erd, input logic eerr, input bit hold);
        exp_t e;
        bit   ok;
        int   acc;
        @(negedge clk);
        req_wr = wr; req_addr = addr; req_size = sz; req_unsigned = uns; req_wdata = wd;
        vld[w] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rdy[w]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout (inst %0d addr %h): req_ready never high", w, addr);
            vld[w] = 1'b0;
            return;
        end
        acc = cyc + 1;
        req_id++;
        e = '{rdata: erd, err: eerr, cyc: acc + wl(w) + 1, w: w, id: req_id};
        sbq.push_back(e);
        // Busy window: scramble the inputs, which must be ignored.
        for (int k = 0; k < wl(w) + 2; k++) begin
            @(negedge clk);
            if (!hold) vld[w] = 1'b0;
            req_wr       = 1'($urandom);
            req_addr     = {$urandom, $urandom};
            req_size     = 2'($urandom);
            req_unsigned = 1'($urandom);
            req_wdata    = {$urandom, $urandom};
            chk("ready_busy", req_id, 64'(rdy[w]), 64'd0);
        end
    endtask

    // Monitor: pop and compare whenever any instance pulses resp_valid.
    always @(negedge clk) begin
        exp_t e;
        for (int w = 0; w < 3; w++) begin
            if (!reset && rv[w]) begin
                if (sbq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_resp inst %0d: got rdata %h err %0d, expected none", w, rd[w], er[w]);
                end else begin
                    e = sbq.pop_front();
                    chk("resp_inst",  e.id, 64'(w),     64'(e.w));
                    chk("resp_cycle", e.id, 64'(cyc),   64'(e.cyc));
                    chk("resp_rdata", e.id, rd[w],      e.rdata);
                    chk("resp_err",   e.id, 64'(er[w]), 64'(e.err));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req_wr = 1'b0; req_addr = 64'd0; req_size = 2'd0; req_unsigned = 1'b0; req_wdata = 64'd0;
        for (int w = 0; w < 3; w++) vld[w] = 1'b0;
        for (int i = 0; i < 32; i++) exp_mem[i] = img(i);

        repeat (2) @(negedge clk);
        for (int w = 0; w < 3; w++) begin
            chk("rst_ready", w, 64'(rdy[w]), 64'd1);
            chk("rst_valid", w, 64'(rv[w]),  64'd0);
            chk("rst_rdata", w, rd[w],       64'd0);
            chk("rst_err",   w, 64'(er[w]),  64'd0);
        end
        reset = 1'b0;

        // Loads, stores, lane merging and extension (WAIT_CYCLES = 1)
        do_req(1, 0, 64'h10, 2'd3, 0, 64'd0, img(2), 0, 0);
        do_req(1, 1, 64'h20, 2'd3, 0, 64'hFFEE_DDCC_BBAA_9988, 64'd0, 0, 0);
        exp_mem[4] = 64'hFFEE_DDCC_BBAA_9988;
        do_req(1, 0, 64'h21, 2'd0, 0, 64'd0, 64'hFFFF_FFFF_FFFF_FF99, 0, 0);
        do_req(1, 0, 64'h22, 2'd1, 1, 64'd0, 64'h0000_0000_0000_BBAA, 0, 0);
        do_req(1, 1, 64'h23, 2'd0, 0, 64'h1234_5678_9ABC_DE7F, 64'd0, 0, 0);
        exp_mem[4] = 64'hFFEE_DDCC_7FAA_9988;
        do_req(1, 0, 64'h20, 2'd3, 1, 64'd0, 64'hFFEE_DDCC_7FAA_9988, 0, 0);
        do_req(1, 0, 64'h24, 2'd2, 0, 64'd0, 64'hFFFF_FFFF_FFEE_DDCC, 0, 0);
        do_req(1, 0, 64'h24, 2'd2, 1, 64'd0, 64'h0000_0000_FFEE_DDCC, 0, 0);
        do_req(1, 0, 64'h22, 2'd1, 0, 64'd0, 64'h0000_0000_0000_7FAA, 0, 0);
        do_req(1, 0, 64'h26, 2'd1, 0, 64'd0, 64'hFFFF_FFFF_FFFF_FFEE, 0, 0);
        do_req(1, 0, 64'h27, 2'd0, 1, 64'd0, 64'h0000_0000_0000_00FF, 0, 0);
        do_req(1, 1, 64'h2E, 2'd1, 0, 64'hAAAA_BBBB_CCCC_1234, 64'd0, 0, 0);
        exp_mem[5] = 64'h1234_0000_0000_0000;
        do_req(1, 1, 64'hF8, 2'd3, 0, 64'hA5A5_5A5A_0F0F_F0F0, 64'd0, 0, 0);
        exp_mem[31] = 64'hA5A5_5A5A_0F0F_F0F0;
        do_req(1, 0, 64'hFF, 2'd0, 1, 64'd0, 64'h0000_0000_0000_00A5, 0, 0);

        // Misaligned and out-of-range accesses
        do_req(1, 0, 64'h06, 2'd2, 0, 64'd0, 64'd0, 1, 0);
        do_req(1, 0, 64'h0C, 2'd3, 0, 64'd0, 64'd0, 1, 0);
        do_req(1, 1, 64'h100, 2'd3, 0, 64'hDEAD_BEEF_DEAD_BEEF, 64'd0, 1, 0);
        do_req(1, 1, 64'h21, 2'd1, 0, 64'h0000_0000_0000_1111, 64'd0, 1, 0);
        do_req(1, 1, 64'h2A, 2'd2, 0, 64'h0000_0000_2222_2222, 64'd0, 1, 0);
        do_req(1, 1, 64'h1000_0000_0000_0020, 2'd3, 0, 64'hDEAD_BEEF_DEAD_BEEF, 64'd0, 1, 0);
        do_req(1, 0, 64'h8000_0000_0000_0010, 2'd3, 0, 64'd0, 64'd0, 1, 0);
        do_req(1, 0, 64'h101, 2'd0, 0, 64'd0, 64'd0, 1, 0);

        // Full readback: only the intended stores may have landed
        for (int i = 0; i < 32; i++) begin
            do_req(1, 0, 64'(i * 8), 2'd3, 0, 64'd0, exp_mem[i], 0, 0);
        end

        // Reset while a store to 0x08 sits in WAIT
        @(negedge clk);
        req_wr = 1'b1; req_addr = 64'h08; req_size = 2'd3; req_unsigned = 1'b0;
        req_wdata = 64'h5555_6666_7777_8888;
        vld[1] = 1'b1;
        chk("rstmid_ready_before", 0, 64'(rdy[1]), 64'd1);
        @(negedge clk);
        vld[1] = 1'b0;
        chk("rstmid_busy", 0, 64'(rdy[1]), 64'd0);
        reset = 1'b1;
        #1;
        chk("rstmid_ready_now", 0, 64'(rdy[1]), 64'd1);
        chk("rstmid_no_valid",  0, 64'(rv[1]),  64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("rstmid_ready_after", 0, 64'(rdy[1]), 64'd1);
        do_req(1, 0, 64'h08, 2'd3, 0, 64'd0, img(1), 0, 0);
        do_req(1, 0, 64'h20, 2'd3, 0, 64'd0, img(4), 0, 0);

        // Back-to-back with valid held high, WAIT_CYCLES = 0 and 4
        for (int w = 0; w < 3; w += 2) begin
            do_req(w, 1, 64'h18, 2'd3, 0, 64'h0123_4567_89AB_CDEF, 64'd0, 0, 1);
            do_req(w, 0, 64'h18, 2'd3, 0, 64'd0, 64'h0123_4567_89AB_CDEF, 0, 1);
            do_req(w, 0, 64'h1F, 2'd0, 0, 64'd0, 64'h0000_0000_0000_0001, 0, 1);
            do_req(w, 0, 64'h1C, 2'd2, 0, 64'd0, 64'h0000_0000_0123_4567, 0, 1);
            do_req(w, 0, 64'h1B, 2'd1, 0, 64'd0, 64'd0, 1, 0);
        end

        repeat (8) @(negedge clk);
        chk("sb_drained", 0, 64'(sbq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
